// File: rtl/hazard_tracker_if.sv
// hazard_tracker_if: ID-stage request and forwarding/stall response bundle.
//   master: decode side, drives the i_* fields and observes the o_* fields.
//   slave : hazard_tracker, consumes i_* and produces o_*.
interface hazard_tracker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             i_id_valid;
  logic [4:0]       i_id_rs;
  logic [4:0]       i_id_rt;
  logic             i_id_use_rs;
  logic             i_id_use_rt;
  logic [4:0]       i_id_rd;
  logic             i_id_reg_write;
  logic             i_id_mem_read;
  logic             i_flush;
  logic             i_halt;

  logic [4:0]       o_ex_rd;
  logic [4:0]       o_mem_rd;
  logic [4:0]       o_wb_rd;
  logic             o_ex_reg_write;
  logic             o_mem_reg_write;
  logic             o_wb_reg_write;
  logic             o_stall;
  logic             o_bubble;
  logic [CNT_W-1:0] o_stall_count;

  modport master (
    output i_id_valid, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_rd,
           i_id_reg_write, i_id_mem_read, i_flush, i_halt,
    input  o_ex_rd, o_mem_rd, o_wb_rd, o_ex_reg_write, o_mem_reg_write,
           o_wb_reg_write, o_stall, o_bubble, o_stall_count
  );

  modport slave (
    input  i_id_valid, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_rd,
           i_id_reg_write, i_id_mem_read, i_flush, i_halt,
    output o_ex_rd, o_mem_rd, o_wb_rd, o_ex_reg_write, o_mem_reg_write,
           o_wb_reg_write, o_stall, o_bubble, o_stall_count
  );
endinterface

// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks destination register / write-enable / load flag of the
// instructions in EX, MEM and WB for the ID forwarding selector, detects
// load-use hazards that forwarding cannot cover and raises stall + bubble.
// A saturating counter records the number of stalled cycles.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : hazard_tracker_if slave (ID inputs, per-stage outputs, stall,
//             bubble, stall counter)
module hazard_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  hazard_tracker_if.slave bus
);

  // WB keeps no load flag: nothing downstream of WB needs it.
  logic [4:0]       ex_rd_q,  mem_rd_q,  wb_rd_q;
  logic             ex_we_q,  mem_we_q,  wb_we_q;
  logic             ex_ld_q,  mem_ld_q;
  logic [CNT_W-1:0] cnt_q;

  logic id_we;
  logic rs_haz;
  logic rt_haz;
  logic haz;
  logic stall;
  logic accept;

  // Load results are only forwardable from WB, so a load in EX or MEM whose
  // destination matches a used source forces a stall.
  function automatic logic load_hit(input logic [4:0] src,
                                    input logic ex_we, input logic ex_ld,
                                    input logic [4:0] ex_rd,
                                    input logic mem_we, input logic mem_ld,
                                    input logic [4:0] mem_rd);
    return (ex_we && ex_ld && (ex_rd == src)) || (mem_we && mem_ld && (mem_rd == src));
  endfunction

  always_comb begin
    id_we  = bus.i_id_reg_write && (bus.i_id_rd != 5'd0);
    rs_haz = bus.i_id_use_rs && (bus.i_id_rs != 5'd0) &&
             load_hit(bus.i_id_rs, ex_we_q, ex_ld_q, ex_rd_q, mem_we_q, mem_ld_q, mem_rd_q);
    rt_haz = bus.i_id_use_rt && (bus.i_id_rt != 5'd0) &&
             load_hit(bus.i_id_rt, ex_we_q, ex_ld_q, ex_rd_q, mem_we_q, mem_ld_q, mem_rd_q);
    // Flush wins over a hazard: the squashed instruction never stalls.
    haz    = bus.i_id_valid && !bus.i_flush && (rs_haz || rt_haz);
    stall  = haz && !bus.i_halt;
    accept = bus.i_id_valid && !bus.i_flush && !haz;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_rd_q  <= 5'd0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      mem_we_q <= 1'b0;
      mem_ld_q <= 1'b0;
      wb_rd_q  <= 5'd0;
      wb_we_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (!bus.i_halt) begin
      wb_rd_q  <= mem_rd_q;
      wb_we_q  <= mem_we_q;
      mem_rd_q <= ex_rd_q;
      mem_we_q <= ex_we_q;
      mem_ld_q <= ex_ld_q;
      if (accept) begin
        ex_rd_q <= bus.i_id_rd;
        ex_we_q <= id_we;
        ex_ld_q <= bus.i_id_mem_read;
      end else begin
        ex_rd_q <= 5'd0;
        ex_we_q <= 1'b0;
        ex_ld_q <= 1'b0;
      end
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.o_ex_rd         = ex_rd_q;
  assign bus.o_mem_rd        = mem_rd_q;
  assign bus.o_wb_rd         = wb_rd_q;
  assign bus.o_ex_reg_write  = ex_we_q;
  assign bus.o_mem_reg_write = mem_we_q;
  assign bus.o_wb_reg_write  = wb_we_q;
  assign bus.o_stall         = stall;
  assign bus.o_bubble        = stall;
  assign bus.o_stall_count   = cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
module tb_hazard_tracker;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   cmp_en;

  hazard_tracker_if #(.CNT_W(CNT_W)) bus ();

  hazard_tracker #(.CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ent_t;

  ent_t        pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
  int unsigned m_cnt;

  function automatic bit load_pending(input logic [4:0] r);
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].we && pipe[k].ld && pipe[k].rd == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_haz();
    if (!bus.i_id_valid || bus.i_flush) return 1'b0;
    return (bus.i_id_use_rs && bus.i_id_rs != 0 && load_pending(bus.i_id_rs)) ||
           (bus.i_id_use_rt && bus.i_id_rt != 0 && load_pending(bus.i_id_rt));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    m_cnt = 0;
  endtask

  initial model_clear();

  always @(posedge rst) model_clear();

  always @(posedge clk) begin
    bit   h;
    ent_t nxt;
    if (!rst && !bus.i_halt) begin
      h = m_haz();
      if (h && m_cnt < CMAX) m_cnt++;
      nxt = '0;
      if (bus.i_id_valid && !bus.i_flush && !h) begin
        nxt.rd = bus.i_id_rd;
        nxt.we = bus.i_id_reg_write && bus.i_id_rd != 0;
        nxt.ld = bus.i_id_mem_read;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit es;
      es = m_haz() && !bus.i_halt && !rst;
      chk("ex_rd",  32'(bus.o_ex_rd),         32'(pipe[0].rd));
      chk("ex_we",  32'(bus.o_ex_reg_write),  32'(pipe[0].we));
      chk("mem_rd", 32'(bus.o_mem_rd),        32'(pipe[1].rd));
      chk("mem_we", 32'(bus.o_mem_reg_write), 32'(pipe[1].we));
      chk("wb_rd",  32'(bus.o_wb_rd),         32'(pipe[2].rd));
      chk("wb_we",  32'(bus.o_wb_reg_write),  32'(pipe[2].we));
      chk("stall",  32'(bus.o_stall),         32'(es));
      chk("bubble", 32'(bus.o_bubble),        32'(es));
      chk("count",  32'(bus.o_stall_count),   m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt, input logic [4:0] rd,
                        input bit rw, input bit mr, input bit fl, input bit hl);
    bus.i_id_valid     = v;
    bus.i_id_rs        = rs;
    bus.i_id_rt        = rt;
    bus.i_id_use_rs    = urs;
    bus.i_id_use_rt    = urt;
    bus.i_id_rd        = rd;
    bus.i_id_reg_write = rw;
    bus.i_id_mem_read  = mr;
    bus.i_flush        = fl;
    bus.i_halt         = hl;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lw(input logic [4:0] rd);
    set_id(1, 5'd0, 5'd0, 0, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 0;
    rst      = 0;
    idle();
    #1 rst = 1;
    cmp_en = 1;
    step();
    chk("rst_ex_rd", 32'(bus.o_ex_rd), 0);
    chk("rst_stall", 32'(bus.o_stall), 0);
    chk("rst_count", 32'(bus.o_stall_count), 0);
    rst = 0;
    step();

    // lw $8 ; add $9,$8,$1 -> two stall cycles, ex_rd 8,0,0,9
    lw(8); step();
    chk("t1_ex8", 32'(bus.o_ex_rd), 8);
    set_id(1, 8, 1, 1, 1, 9, 1, 0, 0, 0); #1;
    chk("t1_stall_a", 32'(bus.o_stall), 1);
    step();
    chk("t1_ex0a", 32'(bus.o_ex_rd), 0);
    chk("t1_stall_b", 32'(bus.o_bubble), 1);
    step();
    chk("t1_ex0b", 32'(bus.o_ex_rd), 0);
    chk("t1_stall_c", 32'(bus.o_stall), 0);
    chk("t1_count", 32'(bus.o_stall_count), 2);
    step();
    chk("t1_ex9", 32'(bus.o_ex_rd), 9);
    drain();

    // lw $8 ; independent ; add using rt=8 -> one stall
    lw(8); step();
    set_id(1, 1, 0, 1, 0, 3, 1, 0, 0, 0); #1;
    chk("t2_nostall", 32'(bus.o_stall), 0);
    step();
    set_id(1, 2, 8, 1, 1, 10, 1, 0, 0, 0); #1;
    chk("t2_stall", 32'(bus.o_stall), 1);
    step();
    chk("t2_stall_end", 32'(bus.o_stall), 0);
    chk("t2_count", 32'(bus.o_stall_count), 3);
    step();
    chk("t2_ex10", 32'(bus.o_ex_rd), 10);
    drain();

    // writes to $0 and unused sources never stall
    lw(0); step();
    chk("t3_ex_we0", 32'(bus.o_ex_reg_write), 0);
    set_id(1, 0, 0, 1, 1, 5, 1, 0, 0, 0); #1;
    chk("t3_zero_src", 32'(bus.o_stall), 0);
    step();
    lw(8); step();
    set_id(1, 8, 2, 0, 1, 5, 1, 0, 0, 0); #1;
    chk("t3_unused_rs", 32'(bus.o_stall), 0);
    step();
    drain();

    // flush beats hazard
    lw(8); step();
    set_id(1, 8, 0, 1, 0, 9, 1, 0, 1, 0); #1;
    chk("t4_flush_stall", 32'(bus.o_stall), 0);
    step();
    chk("t4_ex_we", 32'(bus.o_ex_reg_write), 0);
    chk("t4_ex_rd", 32'(bus.o_ex_rd), 0);
    drain();

    // halt in the middle of a load-use stall
    lw(8); step();
    set_id(1, 8, 0, 1, 0, 9, 1, 0, 0, 0);
    step();
    chk("t5_count_a", 32'(bus.o_stall_count), 4);
    bus.i_halt = 1; #1;
    chk("t5_halt_stall", 32'(bus.o_stall), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_ex", 32'(bus.o_ex_rd), 0);
      chk("t5_hold_mem", 32'(bus.o_mem_rd), 8);
      chk("t5_hold_cnt", 32'(bus.o_stall_count), 4);
    end
    bus.i_halt = 0; #1;
    chk("t5_resume_stall", 32'(bus.o_stall), 1);
    step();
    chk("t5_count_b", 32'(bus.o_stall_count), 5);
    chk("t5_wb8", 32'(bus.o_wb_rd), 8);
    step();
    chk("t5_ex9", 32'(bus.o_ex_rd), 9);
    drain();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_id($urandom_range(0, 99) < 85,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 3)),
             $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8);
      step();
    end
    rst = 0;
    drain();

    // back-to-back load-use pairs until the counter saturates
    for (int n = 0; n < 600; n++) begin
      lw(8); step();
      set_id(1, 8, 0, 1, 0, 9, 1, 0, 0, 0);
      repeat (3) step();
    end
    chk("sat_a", 32'(bus.o_stall_count), CMAX);
    for (int n = 0; n < 5; n++) begin
      lw(8); step();
      set_id(1, 8, 0, 1, 0, 9, 1, 0, 0, 0);
      repeat (3) step();
    end
    chk("sat_b", 32'(bus.o_stall_count), CMAX);

    // asynchronous reset mid-stall
    lw(8); step();
    set_id(1, 8, 0, 1, 0, 9, 1, 0, 0, 0); #1;
    chk("rst_mid_pre", 32'(bus.o_stall), 1);
    rst = 1; #1;
    chk("rst_mid_stall", 32'(bus.o_stall), 0);
    chk("rst_mid_ex", 32'(bus.o_ex_rd), 0);
    chk("rst_mid_exwe", 32'(bus.o_ex_reg_write), 0);
    chk("rst_mid_cnt", 32'(bus.o_stall_count), 0);
    step();
    rst = 0;
    idle();
    step();
    step();

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Producer side of the ID-stage forwarding path. Captures each decoded instruction's destination register, write-enable and load flag, and shifts them through EX, MEM and WB. The resulting `o_*_rd` / `o_*_reg_write` triplets drive the ID forwarding selector. The block also detects load-use hazards that forwarding cannot cover, emits the stall/bubble control, and keeps a saturating stall-cycle counter for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `i_clk`, input, 1: the block's single clock; all state updates on its rising edge.
- `i_reset`, input, 1: reset, asynchronous and active-high.
- `i_id_valid`, input, 1: the ID stage holds a real instruction.
- `i_id_rs`, `i_id_rt`, input, 5 each: source registers of the instruction in ID.
- `i_id_use_rs`, `i_id_use_rt`, input, 1 each: the instruction actually reads rs / rt.
- `i_id_rd`, input, 5: destination after the RegDst/link mux.
- `i_id_reg_write`, input, 1: the ID instruction writes the register file.
- `i_id_mem_read`, input, 1: the ID instruction is a load.
- `i_flush`, input, 1: squash the instruction currently in ID (taken branch/jump).
- `i_halt`, input, 1: freeze all internal state.
- `o_ex_rd`, `o_mem_rd`, `o_wb_rd`, output, 5 each: destination register per stage.
- `o_ex_reg_write`, `o_mem_reg_write`, `o_wb_reg_write`, output, 1 each: write-enable per stage.
- `o_stall`, output, 1: hold PC and IF/ID this cycle.
- `o_bubble`, output, 1: load a NOP into ID/EX this cycle.
- `o_stall_count`, output, `CNT_W`: saturating count of stalled cycles.

## Operation
- Each stage register holds three fields: `rd[4:0]`, `we`, `ld`. EX, MEM and WB register are kept; `ld` is internal only.
- Effective ID write-enable is `i_id_reg_write && i_id_rd != 0`. A write to `$0` is never tracked.
- Hazard condition `haz`: `i_id_valid && !i_flush` and, for rs or rt, all of:
  - the use flag for that source is set;
  - the source register is non-zero;
  - the source matches (EX.we && EX.ld && EX.rd) or (MEM.we && MEM.ld && MEM.rd).
- Load data is forwardable only from WB. ALU results in EX and MEM never stall.
- `o_stall = o_bubble = haz && !i_halt`. Both are combinational from the stage registers and the ID inputs.
- Advance rule, every edge when `!i_halt`:
  - WB ← MEM;
  - MEM ← EX;
  - EX ← ID fields if `i_id_valid && !i_flush && !haz`, otherwise zero (bubble).
- `i_halt = 1`: all stage registers and the counter hold; `o_stall = 0`.
- Counter: increments by 1 on each edge where `o_stall = 1`, and saturates at all-ones. There is no wrap.
- `i_flush` together with `haz`: the flush wins. No stall is raised and EX receives a bubble.
- Stall duration:
  - load in EX with a dependent instruction in ID: 2 consecutive stall cycles (load in EX, then load in MEM);
  - dependent instruction two slots behind the load: 1 cycle;
  - three or more slots behind: 0 cycles.
- A stalled ID instruction is re-evaluated every cycle. No internal FSM beyond the stage registers is needed.

## Timing
- Reset, asynchronous on `i_reset` high: all stage fields are 0, `o_*_rd = 0`, `o_*_reg_write = 0`, `o_stall = o_bubble = 0`, `o_stall_count = 0`.
- Release takes effect on the first rising edge after `i_reset` falls.
- Reset asserted mid-stall clears the in-flight load immediately, so `o_stall` drops in the same cycle (combinationally).
- Pipeline latency is 1 cycle per stage:
  - an ID instruction accepted at edge N appears on `o_ex_*` after N;
  - it appears on `o_mem_*` after N+1;
  - it appears on `o_wb_*` after N+2.
- The WB entry is held for exactly one cycle and then overwritten.
- `o_stall_count` reflects a stall cycle one edge after that cycle.

## Test plan
- `lw $8` followed by `add $9,$8,$1` (uses rs=8): `o_stall = 1` for exactly 2 cycles with bubbles, then no stall. `o_ex_rd` sequence is 8, 0, 0, 9. Counter ends at 2.
- `lw $8`, an independent instruction, then `add` using rt=8: exactly 1 stall cycle. Counter increases by 1.
- `lw $0` followed by a use of `$0`; also a use with `i_id_use_rs = 0`: no stall. For `lw $0`, `o_ex_reg_write = 0`.
- A dependent instruction in ID with `i_flush = 1` while a load is in EX: `o_stall = 0`, and the next edge gives `o_ex_reg_write = 0`, `o_ex_rd = 0`.
- `i_halt` held high for 3 cycles in the middle of a load-use stall: all outputs frozen and the counter unchanged. After release the remaining stall cycle occurs.
- 40000 back-to-back load-use pairs: `o_stall_count` reaches 16'hFFFF and stays there. An `i_reset` pulse mid-stall sets all outputs to 0 asynchronously.
